// File: rtl/updown_tick_ctrl.sv
// Run/pause/stop controller for a bounded up/down counter, paced by a tick-enable prescaler.
// Define UPDOWN_TICK_CTRL_SATURATE_EN to hold the count at its bounds instead of wrapping.
module updown_tick_ctrl #(
    parameter int unsigned DIV   = 25000000,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 9,
    parameter int unsigned MIN   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             wrap_o,
    output logic             running_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    localparam logic [31:0]      PreLast = 32'(DIV - 1);
    localparam logic [WIDTH-1:0] CntMax  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] CntMin  = WIDTH'(MIN);

    state_e           state_q, state_d;
    logic [31:0]      pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             running_q, running_d;

    logic             terminal;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;
    logic [WIDTH-1:0] load_clamped;

    assign terminal = (state_q == StRun) && (pre_q == PreLast);

    always_comb begin
        step_val  = count_q;
        step_wrap = 1'b0;
        if (dir_i) begin
            if (count_q == CntMax) begin
                step_wrap = 1'b1;
`ifdef UPDOWN_TICK_CTRL_SATURATE_EN
                step_val  = count_q;
`else
                step_val  = CntMin;
`endif
            end else begin
                step_val = count_q + 1'b1;
            end
        end else begin
            if (count_q == CntMin) begin
                step_wrap = 1'b1;
`ifdef UPDOWN_TICK_CTRL_SATURATE_EN
                step_val  = count_q;
`else
                step_val  = CntMax;
`endif
            end else begin
                step_val = count_q - 1'b1;
            end
        end
    end

    // Equality with MIN also maps to MIN, which keeps the compare non-trivial when MIN is 0.
    always_comb begin
        load_clamped = load_val_i;
        if (load_val_i > CntMax) begin
            load_clamped = CntMax;
        end else if (load_val_i <= CntMin) begin
            load_clamped = CntMin;
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                pre_d = terminal ? 32'd0 : pre_q + 32'd1;
                if (terminal) begin
                    count_d = step_val;
                    tick_d  = 1'b1;
                    wrap_d  = step_wrap;
                end
                if (stop_i) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (stop_i) begin
                    state_d = StIdle;
                    pre_d   = 32'd0;
                    count_d = CntMin;
                end else if (start_i) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Load beats any step; the prescaler keeps its own schedule.
        if (load_i) begin
            count_d = load_clamped;
            tick_d  = 1'b0;
            wrap_d  = 1'b0;
        end
    end

    assign running_d = (state_d == StRun);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            pre_q     <= 32'd0;
            count_q   <= CntMin;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign count_o   = count_q;
    assign tick_o    = tick_q;
    assign wrap_o    = wrap_q;
    assign running_o = running_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_updown_tick_ctrl.sv
// Scoreboard bench for updown_tick_ctrl (DIV=4, MAX=9, MIN=0): stimulus queues expected ticks,
// a monitor checks every tick against the queue, and state checks run inline.
module tb_updown_tick_ctrl;

    localparam int unsigned Width = 4;

`ifdef UPDOWN_TICK_CTRL_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       wr;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             dir;
    logic             load;
    logic [Width-1:0] load_val;
    logic [Width-1:0] count;
    logic             tick;
    logic             wrap;
    logic             running;
    logic [1:0]       state;

    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    updown_tick_ctrl #(
        .DIV   (4),
        .WIDTH (Width),
        .MAX   (9),
        .MIN   (0)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .dir_i      (dir),
        .load_i     (load),
        .load_val_i (load_val),
        .count_o    (count),
        .tick_o     (tick),
        .wrap_o     (wrap),
        .running_o  (running),
        .state_o    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int cnt, input bit wr);
        exp_t e;
        e.cyc = c;
        e.cnt = 4'(cnt);
        e.wr  = wr;
        exp_q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every tick must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: count %0d wrap %0d at cycle %0d", count, wrap, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_count", int'(count), int'(e.cnt));
                check("tick_wrap", int'(wrap), int'(e.wr));
            end
        end else if (wrap === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wrap_without_tick: wrap 1, tick 0 at cycle %0d", cyc);
        end
    end

    initial begin
        int t;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        dir      = 1'b1;
        load     = 1'b0;
        load_val = '0;
        wait_n(3);
        check("reset_count", int'(count), 0);
        check("reset_state", int'(state), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_running", int'(running), 0);

        // Count up 0..9,0 with a tick every 4 cycles and wrap only on 9->0.
        rst   = 1'b0;
        t     = cyc;
        for (int k = 1; k <= 10; k++) push(t + 1 + 4 * k, k % 10, k == 10);
        start = 1'b1;
        wait_n(20);
        check("run_running", int'(running), 1);
        check("run_state", int'(state), 1);
        wait_n(21);

        // Pause with pre==2, hold 10 cycles, resume: tick 2 cycles later.
        wait_n(2);
        start = 1'b0;
        stop  = 1'b1;
        wait_n(1);
        stop  = 1'b0;
        check("pause_state", int'(state), 2);
        check("pause_running", int'(running), 0);
        wait_n(10);
        check("pause_held_state", int'(state), 2);
        check("pause_held_count", int'(count), 0);
        t     = cyc;
        push(t + 2, 1, 1'b0);
        start = 1'b1;
        wait_n(2);

        // Load 0 then count down across MIN.
        t        = cyc;
        load     = 1'b1;
        load_val = 4'd0;
        wait_n(1);
        load     = 1'b0;
        dir      = 1'b0;
        check("load_zero", int'(count), 0);
        push(t + 4, Sat ? 0 : 9, 1'b1);
        push(t + 8, Sat ? 0 : 8, Sat);
        wait_n(10);

        // Load 13 on the terminal cycle: clamps to 9, no tick, prescaler still wraps.
        load     = 1'b1;
        load_val = 4'd13;
        wait_n(1);
        load     = 1'b0;
        check("load_clamp", int'(count), 9);
        check("load_tick", int'(tick), 0);
        check("load_wrap", int'(wrap), 0);
        push(t + 16, 8, 1'b0);
        wait_n(4);

        // start+stop in RUN -> PAUSE, stop again -> IDLE with count and pre cleared.
        t     = cyc;
        stop  = 1'b1;
        wait_n(1);
        check("both_state", int'(state), 2);
        start = 1'b0;
        wait_n(1);
        check("idle_state", int'(state), 0);
        check("idle_count", int'(count), 0);
        stop  = 1'b0;
        start = 1'b1;
        push(t + 7, Sat ? 0 : 9, 1'b1);
        wait_n(5);

        // Reset mid-RUN at count 5 while loading.
        load     = 1'b1;
        load_val = 4'd5;
        wait_n(1);
        check("load_five", int'(count), 5);
        rst      = 1'b1;
        load_val = 4'd7;
        wait_n(1);
        check("rst_count", int'(count), 0);
        check("rst_state", int'(state), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_running", int'(running), 0);
        rst   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        wait_n(8);
        check("idle_hold_state", int'(state), 0);
        check("pending_ticks", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_tick_ctrl.md
Name: updown_tick_ctrl

Overview:
Run/pause/stop controller for a bounded up/down counter, paced by an internal prescaler. It replaces the free-running divided clock with a single-cycle tick enable, so the whole counter datapath stays on one clock. It sequences counting through IDLE/RUN/PAUSE, supports synchronous load, and flags wrap events for cascading digits.

Parameters:
DIV, 25000000, prescaler terminal count; one tick per DIV clk cycles while running; legal range is DIV >= 1.
WIDTH, 4, width of count and load_val.
MAX, 9, upper count bound (inclusive); must satisfy MIN < MAX < 2^WIDTH.
MIN, 0, lower count bound (inclusive).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
start  in  1  level; enter or resume RUN.
stop  in  1  level; RUN->PAUSE, PAUSE->IDLE.
dir  in  1  1 = count up, 0 = count down; sampled on the terminal cycle.
load  in  1  synchronous load strobe.
load_val  in  WIDTH  load value.
count  out  WIDTH  current count.
tick  out  1  one-cycle pulse, high in the cycle after a step edge.
wrap  out  1  one-cycle pulse, high together with a tick whose step crossed a bound.
running  out  1  high when state == RUN.
state  out  2  current state: IDLE=00, RUN=01, PAUSE=10; 11 is unreachable and decodes to IDLE.

Behaviour:
- All outputs are registered.
- Reset values: count=MIN, tick=0, wrap=0, running=0, state=IDLE, internal 32-bit prescaler pre=0.
- rst overrides every other input on the same edge, including mid-RUN and mid-load.
- Prescaler:
  - Increments only in RUN.
  - When pre==DIV-1 in RUN (the "terminal cycle"), pre returns to 0 and count steps at that edge.
  - tick and wrap are high for exactly the following cycle, coincident with the new count.
  - With DIV=1, tick is high every cycle in RUN.
- State transitions:
  - IDLE: start -> RUN; otherwise stay. count is held.
  - RUN: stop -> PAUSE; otherwise stay.
  - PAUSE: start -> RUN; stop -> IDLE.
  - start and stop together: stop wins.
- Prescaler state across transitions:
  - PAUSE freezes pre at its current value; resuming continues from it, so there is no phase loss.
  - The PAUSE->IDLE transition clears pre to 0 and count to MIN on the same edge.
- Step on a terminal cycle:
  - dir=1: count==MAX -> MIN with wrap; otherwise count+1.
  - dir=0: count==MIN -> MAX with wrap; otherwise count-1.
- Terminal cycle coinciding with stop: the step still occurs, and the state becomes PAUSE on the same edge.
- Load:
  - Allowed in any state. count <= load_val, clamped to MAX if above MAX and to MIN if below MIN.
  - Load has priority over a step in the same cycle; that cycle's tick and wrap are suppressed, but pre still wraps.
  - Load does not change state or pre.
- A count outside [MIN,MAX] is unreachable except via the clamp rule.

Optional Feature:
UPDOWN_TICK_CTRL_SATURATE_EN
- Defined: a step at a bound holds count (up at MAX stays MAX; down at MIN stays MIN). tick still pulses and wrap pulses as a "blocked" indicator.
- Undefined: wrap-around behaviour as above.

Test Plan:
1. DIV=4, MAX=9, MIN=0: rst, start held, dir=1 -> tick every 4 cycles; count 0,1,...,9,0; wrap high only on the 9->0 tick; running=1.
2. RUN with pre==2 (DIV=4): stop for 1 cycle, wait 10 cycles, then start -> state=10 and count frozen during the pause; first tick comes exactly 2 cycles after resume.
3. count=0, dir=0, terminal cycle -> count=9, wrap=1, tick=1 for one cycle. With SATURATE_EN defined: count stays 0, wrap=1.
4. load=1, load_val=13 on a terminal cycle -> count=9 (clamp), tick=0, wrap=0 the next cycle; pre=0 afterwards.
5. start and stop asserted together in RUN -> PAUSE; stop again -> IDLE, count=0, pre=0.
6. rst asserted mid-RUN at count=5 with load=1 -> next edge: count=0, state=00, tick=0, wrap=0, running=0.
